// File: rtl/branch_tgt_buf.sv
// ---------------------------------------------------------------------------
// branch_tgt_buf
//   Direct-mapped branch target buffer for the fetch stage. A fetch PC is
//   looked up combinationally; resolved branches from EX train the table on
//   the rising clock edge. The fetch-stage hit is carried down the pipe
//   (IM/ID, ID/EX) so EX can tell whether the instruction was predicted taken.
//
//   Optional feature macro: BTB_2BIT_CTR_EN
//     defined   : each entry has a 2-bit saturating counter; hit needs ctr[1].
//     undefined : no counters; hit = valid + tag match, a not-taken update
//                 that matches invalidates the entry.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   pc[15:0]       fetch-stage PC to look up
//   stall_IM_ID    pipe stall (shared with the PC logic)
//   flush          taken flow change resolved in EX; squashes younger stages
//   upd_vld        a branch/jump resolved in EX this cycle
//   upd_pc[15:0]   address of the resolved branch
//   upd_taken      resolved direction
//   upd_tgt[15:0]  resolved target
//   btb_hit        fetch-stage taken prediction (combinational)
//   btb_nxt_pc     predicted target, 16'h0000 when btb_hit=0
//   btb_hit_ID_EX  btb_hit aligned with the instruction in EX
//
// Update interface: upd_vld is a one-way valid with no ready. The table
// always accepts; an update is consumed on every rising edge where
// upd_vld=1 and rst_n=1, regardless of stall_IM_ID.
// ---------------------------------------------------------------------------
module branch_tgt_buf #(
   parameter int IDX_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pc,
   input  logic        stall_IM_ID,
   input  logic        flush,
   input  logic        upd_vld,
   input  logic [15:0] upd_pc,
   input  logic        upd_taken,
   input  logic [15:0] upd_tgt,
   output logic        btb_hit,
   output logic [15:0] btb_nxt_pc,
   output logic        btb_hit_ID_EX
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int TAG_W = 16 - IDX_W;

   logic [DEPTH-1:0] valid_q;
   logic [TAG_W-1:0] tag_q [DEPTH];
   logic [15:0]      tgt_q [DEPTH];
`ifdef BTB_2BIT_CTR_EN
   logic [1:0]       ctr_q [DEPTH];
`endif

   logic             btb_hit_IM_ID;

   // ------------------------------------------------------------------
   // Lookup: reads the registered table, so an update to the same index
   // in the same cycle is only visible from the next cycle on.
   // ------------------------------------------------------------------
   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag;
   logic             rd_match;

   assign rd_idx   = pc[IDX_W-1:0];
   assign rd_tag   = pc[15:IDX_W];
   assign rd_match = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

`ifdef BTB_2BIT_CTR_EN
   assign btb_hit = rd_match && ctr_q[rd_idx][1];
`else
   assign btb_hit = rd_match;
`endif

   assign btb_nxt_pc = btb_hit ? tgt_q[rd_idx] : 16'h0000;

   // ------------------------------------------------------------------
   // Update
   // ------------------------------------------------------------------
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic             wr_match;

   assign wr_idx   = upd_pc[IDX_W-1:0];
   assign wr_tag   = upd_pc[15:IDX_W];
   assign wr_match = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
`ifdef BTB_2BIT_CTR_EN
            // Weakly not-taken, so a fresh entry never predicts by itself.
            ctr_q[i] <= 2'b01;
`endif
         end
      end else if (upd_vld) begin
`ifdef BTB_2BIT_CTR_EN
         if (wr_match) begin
            if (upd_taken) begin
               ctr_q[wr_idx] <= (ctr_q[wr_idx] == 2'b11) ? 2'b11 : ctr_q[wr_idx] + 2'd1;
               tgt_q[wr_idx] <= upd_tgt;
            end else begin
               ctr_q[wr_idx] <= (ctr_q[wr_idx] == 2'b00) ? 2'b00 : ctr_q[wr_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            // Allocate weakly taken so the next fetch of this branch predicts.
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            tgt_q[wr_idx]   <= upd_tgt;
            ctr_q[wr_idx]   <= 2'b10;
         end
`else
         if (upd_taken) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            tgt_q[wr_idx]   <= upd_tgt;
         end else if (wr_match) begin
            valid_q[wr_idx] <= 1'b0;
         end
`endif
      end
   end

   // ------------------------------------------------------------------
   // Prediction pipe. Flush wins over stall; a stall holds IM/ID and
   // sends a bubble into ID/EX.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btb_hit_IM_ID <= 1'b0;
         btb_hit_ID_EX <= 1'b0;
      end else begin
         if (flush) begin
            btb_hit_IM_ID <= 1'b0;
         end else if (!stall_IM_ID) begin
            btb_hit_IM_ID <= btb_hit;
         end
         btb_hit_ID_EX <= (flush || stall_IM_ID) ? 1'b0 : btb_hit_IM_ID;
      end
   end

endmodule

// File: tb/tb_branch_tgt_buf.sv
module tb_branch_tgt_buf;

  localparam int N = 16;  // 2**IDX_W with the default IDX_W = 4

  // ------------------------------------------------------------------
  // Clock / reset
  // ------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc = '0;
  logic        stall_IM_ID = 1'b0;
  logic        flush = 1'b0;
  logic        upd_vld = 1'b0;
  logic [15:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_tgt = '0;
  logic        btb_hit;
  logic [15:0] btb_nxt_pc;
  logic        btb_hit_ID_EX;

  always #5 clk = ~clk;

  branch_tgt_buf dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc(pc),
    .stall_IM_ID(stall_IM_ID),
    .flush(flush),
    .upd_vld(upd_vld),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_tgt(upd_tgt),
    .btb_hit(btb_hit),
    .btb_nxt_pc(btb_nxt_pc),
    .btb_hit_ID_EX(btb_hit_ID_EX)
  );

  // ------------------------------------------------------------------
  // Reference model: a table of branch records indexed by pc mod N,
  // tagged by pc / N, with counters as plain integers.
  // ------------------------------------------------------------------
  bit          m_valid [N];
  int          m_tag   [N];
  logic [15:0] m_tgt   [N];
  int          m_ctr   [N];
  bit          m_im;
  bit          m_ex;

  int checks = 0;
  int errors = 0;

  // {expected btb_hit_ID_EX, expected btb_hit, expected btb_nxt_pc}
  logic [17:0] exp_q[$];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_im = 1'b0;
    m_ex = 1'b0;
  endfunction

  function automatic bit model_hit(input logic [15:0] p);
    int i;
    bit present;
    i = int'(p) % N;
    present = m_valid[i] && (m_tag[i] == int'(p) / N);
`ifdef BTB_2BIT_CTR_EN
    return present && (m_ctr[i] >= 2);
`else
    return present;
`endif
  endfunction

  function automatic void model_update(input logic [15:0] upc, input bit taken,
                                       input logic [15:0] tgt);
    int i;
    bit present;
    i = int'(upc) % N;
    present = m_valid[i] && (m_tag[i] == int'(upc) / N);
`ifdef BTB_2BIT_CTR_EN
    if (present) begin
      if (taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (taken) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = int'(upc) / N;
      m_tgt[i]   = tgt;
      m_ctr[i]   = 2;
    end
`else
    if (taken) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = int'(upc) / N;
      m_tgt[i]   = tgt;
    end else if (present) begin
      m_valid[i] = 1'b0;
    end
`endif
  endfunction

  // ------------------------------------------------------------------
  // Driver: one fetch cycle. Inputs change just after a rising edge; the
  // expected outputs for this cycle are pushed, then the model advances
  // at the edge exactly as the design should.
  // ------------------------------------------------------------------
  task automatic step(input logic [15:0] p, input bit st, input bit fl,
                      input bit uv, input logic [15:0] upc, input bit ut,
                      input logic [15:0] utgt);
    bit hit;
    bit old_im;
    logic [15:0] nxt;
    pc = p;
    stall_IM_ID = st;
    flush = fl;
    upd_vld = uv;
    upd_pc = upc;
    upd_taken = ut;
    upd_tgt = utgt;
    hit = model_hit(p);
    nxt = hit ? m_tgt[int'(p) % N] : 16'h0000;
    exp_q.push_back({m_ex, hit, nxt});
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (uv) model_update(upc, ut, utgt);
      old_im = m_im;
      if (fl) m_im = 1'b0;
      else if (!st) m_im = hit;
      m_ex = (fl || st) ? 1'b0 : old_im;
    end
    #1;
  endtask

  task automatic look(input logic [15:0] p);
    step(p, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  // ------------------------------------------------------------------
  // Monitor / scoreboard: every cycle with an outstanding expectation,
  // compare on the falling edge.
  // ------------------------------------------------------------------
  always @(negedge clk) begin
    logic [17:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (btb_hit !== e[16]) begin
        errors++;
        $display("FAIL btb_hit t=%0t pc=%h got %b exp %b", $time, pc, btb_hit, e[16]);
      end
      checks++;
      if (btb_nxt_pc !== e[15:0]) begin
        errors++;
        $display("FAIL btb_nxt_pc t=%0t pc=%h got %h exp %h", $time, pc, btb_nxt_pc, e[15:0]);
      end
      checks++;
      if (btb_hit_ID_EX !== e[17]) begin
        errors++;
        $display("FAIL btb_hit_ID_EX t=%0t pc=%h got %b exp %b", $time, pc, btb_hit_ID_EX, e[17]);
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    logic [15:0] p;
    logic [15:0] upc;
    logic [15:0] tgt;
    bit uv, ut, st, fl;

    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Updates while in reset must not land; outputs stay quiet.
    step(16'h0013, 1'b0, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h0077);
    step(16'h0013, 1'b0, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h0077);
    rst_n = 1'b1;

    // Sweep after reset: every pc misses.
    for (int i = 0; i < 256; i++) look(16'(i));

    // Allocate, hit, alias on the same index with another tag.
    step(16'h0013, 1'b0, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h0040);
    look(16'h0013);
    look(16'h0023);

    // Direction training on 0x0013.
    step(16'h0013, 1'b0, 1'b0, 1'b1, 16'h0013, 1'b0, 16'h0000);
    step(16'h0013, 1'b0, 1'b0, 1'b1, 16'h0013, 1'b0, 16'h0000);
    look(16'h0013);
    for (int i = 0; i < 3; i++)
      step(16'h0013, 1'b0, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h0040);
    look(16'h0013);

    // Same-index update and lookup: old contents now, new contents next.
    step(16'h0015, 1'b0, 1'b0, 1'b1, 16'h0015, 1'b1, 16'h1234);
    look(16'h0015);
    step(16'h0013, 1'b0, 1'b0, 1'b1, 16'h0013, 1'b1, 16'h0055);
    look(16'h0013);

    // Two-cycle stall with a hit in fetch.
    look(16'h0013);
    step(16'h0013, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step(16'h0013, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    look(16'h0000);
    look(16'h0000);

    // Flush together with stall clears both stages.
    look(16'h0013);
    look(16'h0013);
    step(16'h0013, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    look(16'h0013);
    look(16'h0013);

    // Random traffic over a few tags so entries collide and retrain.
    for (int n = 0; n < 400; n++) begin
      p   = 16'($urandom_range(0, 3) * N + $urandom_range(0, N - 1));
      upc = 16'($urandom_range(0, 3) * N + $urandom_range(0, N - 1));
      tgt = 16'($urandom);
      uv  = ($urandom_range(0, 1) == 1);
      ut  = ($urandom_range(0, 99) < 60);
      st  = ($urandom_range(0, 9) < 2);
      fl  = ($urandom_range(0, 9) == 0);
      step(p, st, fl, uv, upc, ut, tgt);
    end

    // Second reset, taken mid-cycle; an update held across deassertion
    // lands only at the first edge with rst_n=1.
    rst_n = 1'b0;
    model_reset();
    step(16'h0031, 1'b0, 1'b0, 1'b1, 16'h0031, 1'b1, 16'h0abc);
    look(16'h0013);
    rst_n = 1'b1;
    step(16'h0031, 1'b0, 1'b0, 1'b1, 16'h0031, 1'b1, 16'h0abc);
    look(16'h0031);
    look(16'h0013);

    // Bounded drain of the scoreboard.
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_tgt_buf.md
BRANCH_TGT_BUF -- requirements
Module: branch_tgt_buf

Interface
REQ-001 SHALL define parameter IDX_W, default 4, index width; the table has 2**IDX_W entries.
REQ-002 SHALL have input clk, 1 bit, the rising-edge clock.
REQ-003 SHALL have input rst_n, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have input pc, 16 bits, the fetch-stage PC to look up.
REQ-005 SHALL have input stall_IM_ID, 1 bit, a pipe stall (same signal the PC logic uses).
REQ-006 SHALL have input flush, 1 bit, a taken flow change resolved in EX that squashes younger stages.
REQ-007 SHALL have input upd_vld, 1 bit, meaning a branch or jump resolved in EX this cycle.
REQ-008 SHALL have input upd_pc, 16 bits, the address of the resolved branch instruction.
REQ-009 SHALL have input upd_taken, 1 bit, the resolved direction.
REQ-010 SHALL have input upd_tgt, 16 bits, the resolved target address.
REQ-011 SHALL have output btb_hit, 1 bit, the fetch-stage prediction of taken.
REQ-012 SHALL have output btb_nxt_pc, 16 bits, the predicted target (valid only when btb_hit=1).
REQ-013 SHALL have output btb_hit_ID_EX, 1 bit, btb_hit aligned with the instruction in EX.

Function
REQ-014 SHALL be a direct-mapped table; each entry holds a valid bit, tag[15:IDX_W], target[15:0] and a 2-bit counter ctr.
REQ-015 SHALL index the table with pc[IDX_W-1:0] and compare against pc[15:IDX_W].
REQ-016 SHALL assert btb_hit combinationally, in the same cycle as pc, when valid=1, the tag matches and ctr[1]=1.
REQ-017 SHALL drive btb_nxt_pc from the entry target on a hit and 16'h0000 otherwise.
REQ-018 SHALL write the table only on the rising clk edge when upd_vld=1; the write SHALL ignore stall_IM_ID.
REQ-019 SHALL, on an update that matches the tag, increment ctr (saturating at 2'b11) when taken and decrement it (saturating at 2'b00) when not taken.
REQ-020 SHALL, on a tag-matching taken update, also overwrite the target with upd_tgt.
REQ-021 SHALL, on a taken update that misses or hits an invalid entry, allocate the entry: valid=1, tag from upd_pc, target=upd_tgt, ctr=2'b10.
REQ-022 SHALL leave the table unchanged on a not-taken update that misses.
REQ-023 SHALL give a lookup in the same cycle as an update to the same index the pre-update contents (no bypass).
REQ-024 SHALL register btb_hit_IM_ID as follows: flush clears it to 0; otherwise it holds when stall_IM_ID=1; otherwise it loads btb_hit.
REQ-025 SHALL register btb_hit_ID_EX as 0 when flush or stall_IM_ID is asserted, and as btb_hit_IM_ID otherwise (a stall inserts a bubble).
REQ-026 SHALL give flush priority over stall when both are asserted in the same cycle.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously clear all valid bits, set every ctr to 2'b01 and clear btb_hit_IM_ID and btb_hit_ID_EX.
REQ-028 SHALL return btb_hit=0 and btb_nxt_pc=16'h0000 for every pc while in reset and immediately after it.
REQ-029 SHALL let an update coinciding with reset deassertion take effect only at the first rising edge with rst_n=1.

Configuration
REQ-030 SHALL, when macro BTB_2BIT_CTR_EN is defined, implement the counters as in REQ-016 and REQ-019 to REQ-021.
REQ-031 SHALL, when BTB_2BIT_CTR_EN is undefined, omit ctr storage entirely.
REQ-032 SHALL, without BTB_2BIT_CTR_EN, define hit as valid plus tag match only.
REQ-033 SHALL, without BTB_2BIT_CTR_EN, invalidate a tag-matching entry on a not-taken update and allocate or overwrite on every taken update.

Verification
REQ-034 SHALL check that after reset, sweeping pc over 0x0000 to 0x00FF yields btb_hit=0 throughout.
REQ-035 SHALL check that update (upd_pc=0x0013, taken, tgt=0x0040), followed by pc=0x0013 on the next cycle, gives btb_hit=1 and btb_nxt_pc=0x0040; and that pc=0x0023 (same index, different tag) gives btb_hit=0.
REQ-036 SHALL check that, with counters enabled, two not-taken updates to 0x0013 after allocation take ctr 10 to 01 to 00 and give btb_hit=0; three taken updates then saturate ctr at 11 and give btb_hit=1.
REQ-037 SHALL check that an update and a lookup of the same index in the same cycle return the old entry in that cycle and the new entry in the next cycle.
REQ-038 SHALL check that with btb_hit=1 and stall_IM_ID=1 for 2 cycles, btb_hit_ID_EX=0 during the stall and the held btb_hit_IM_ID=1 reaches btb_hit_ID_EX one cycle after the stall releases.
REQ-039 SHALL check that flush and stall asserted together clear btb_hit_IM_ID and btb_hit_ID_EX to 0.
